// File: rtl/fifo4_serial_tx.sv
// Pops words from a 4-entry FIFO and shifts them out MSB-first as a framed serial stream.
// Latency: the first bit is on sdo the cycle after the fifo_rd pulse; one word takes WIDTH*2*DIV cycles.
// Backpressure: pops only at word boundaries while en=1; running dry at a boundary sets sticky underrun.
//
// Ports:
//   clk        master clock
//   rst        synchronous active-low reset (0 = reset)
//   en         stream enable, sampled only at word boundaries
//   fifo_dout  FIFO RAM word at the current read address (combinational)
//   fifo_empty FIFO empty flag
//   fifo_rd    one-cycle pop confirm, combinational from registered state
//   sclk       serial bit clock; rises DIV cycles into each bit
//   sdo        serial data, changes on the sclk falling edge
//   fs         frame sync, high for the whole first bit of each word
//   busy       high while a word is being shifted
//   underrun   sticky: FIFO was empty at a word boundary with en=1
//   clr_urun   clears underrun (a same-cycle set wins)
module fifo4_serial_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             sclk,
  output logic             sdo,
  output logic             fs,
  output logic             busy,
  output logic             underrun,
  input  logic             clr_urun
);

  localparam int PH_N = 2 * DIV;
  localparam int PW   = (PH_N > 1) ? $clog2(PH_N) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(PH_N - 1);
  // sclk rises when ph_cnt becomes DIV, i.e. while it currently holds DIV-1
  localparam logic [PW-1:0] PH_RISE  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic             sclk_q, sclk_d;
  logic             fs_q, fs_d;
  logic             urun_q, urun_d;

  logic bit_end;
  logic last_bit_end;
  logic load_ok;
  logic rd;
  logic urun_set;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    sclk_d  = sclk_q;
    fs_d    = fs_q;
    urun_d  = urun_q;

    bit_end      = (state_q == SHIFT) && (ph_q == PH_LAST);
    last_bit_end = bit_end && (bit_q == BIT_LAST);
    load_ok      = en && !fifo_empty && rst;
    rd           = load_ok && ((state_q == IDLE) || last_bit_end);
    // Only an enabled stream that runs dry counts as an underrun
    urun_set     = last_bit_end && en && fifo_empty;

    if (rd) begin
      // sdo is the shift register MSB, so loading the word presents bit WIDTH-1
      sr_d    = fifo_dout;
      fs_d    = 1'b1;
      sclk_d  = 1'b0;
      bit_d   = '0;
      ph_d    = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (last_bit_end) begin
        // en low or FIFO dry: word finished, park with all lines low
        state_d = IDLE;
        sr_d    = '0;
        fs_d    = 1'b0;
        sclk_d  = 1'b0;
        bit_d   = '0;
        ph_d    = '0;
      end else if (bit_end) begin
        // sclk falling edge: advance to the next bit
        sr_d   = {sr_q[WIDTH-2:0], 1'b0};
        fs_d   = 1'b0;
        sclk_d = 1'b0;
        bit_d  = bit_q + 1'b1;
        ph_d   = '0;
      end else begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PH_RISE) begin
          sclk_d = 1'b1;
        end
      end
    end

    if (urun_set) begin
      urun_d = 1'b1;
    end else if (clr_urun) begin
      urun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      sclk_q  <= 1'b0;
      fs_q    <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      sclk_q  <= sclk_d;
      fs_q    <= fs_d;
      urun_q  <= urun_d;
    end
  end

  assign fifo_rd  = rd;
  assign sclk     = sclk_q;
  assign sdo      = sr_q[WIDTH-1];
  assign fs       = fs_q;
  assign busy     = (state_q == SHIFT);
  assign underrun = urun_q;

endmodule

// File: tb/tb_fifo4_serial_tx.sv
// Bench for fifo4_serial_tx: queue-based FIFO, word-timeline reference model, randomized traffic.
module tb_fifo4_serial_tx;

  localparam int W   = 16;
  localparam int DIV = 4;
  localparam int BP  = 2 * DIV;   // cycles per bit
  localparam int WP  = W * BP;    // cycles per word

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd;
  logic         sclk;
  logic         sdo;
  logic         fs;
  logic         busy;
  logic         underrun;
  logic         clr_urun;

  fifo4_serial_tx #(.WIDTH(W), .DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .sclk       (sclk),
    .sdo        (sdo),
    .fs         (fs),
    .busy       (busy),
    .underrun   (underrun),
    .clr_urun   (clr_urun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_rd_dut = 0;

  logic [W-1:0] q[$];

  // Reference model: position within the current word and the sticky flag
  bit           m_act;
  int           m_t;
  logic [W-1:0] m_word;
  bit           m_urun;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic upd();
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() == 0) ? W'($urandom) : q[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    if (q.size() < 4) q.push_back(w);
    upd();
  endtask

  task automatic step();
    bit           rd_e;
    bit           n_act;
    int           n_t;
    bit           n_urun;
    @(negedge clk);
    rd_e = rst && en && (q.size() != 0) && (!m_act || m_t == WP - 1);
    chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, rd_e});
    if (fifo_rd) n_rd_dut++;
    if (m_act) begin
      chk("sdo",  {31'd0, sdo},  {31'd0, m_word[W - 1 - m_t / BP]});
      chk("sclk", {31'd0, sclk}, {31'd0, ((m_t % BP) >= DIV)});
      chk("fs",   {31'd0, fs},   {31'd0, (m_t < BP)});
      chk("busy", {31'd0, busy}, 32'd1);
    end else begin
      chk("sdo_idle",  {31'd0, sdo},  32'd0);
      chk("sclk_idle", {31'd0, sclk}, 32'd0);
      chk("fs_idle",   {31'd0, fs},   32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
    end
    chk("underrun", {31'd0, underrun}, {31'd0, m_urun});

    n_act  = m_act;
    n_t    = m_t;
    n_urun = m_urun;
    if (!rst) begin
      n_act = 0; n_t = 0; n_urun = 0;
    end else begin
      if (rd_e) begin
        n_act = 1; n_t = 0;
      end else if (m_act) begin
        if (m_t == WP - 1) n_act = 0;
        else n_t = m_t + 1;
      end
      if (m_act && m_t == WP - 1 && en && q.size() == 0) n_urun = 1;
      else if (clr_urun) n_urun = 0;
    end

    @(posedge clk);
    if (rd_e) m_word = q.pop_front();
    m_act  = n_act;
    m_t    = n_t;
    m_urun = n_urun;
    #1;
    upd();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int rd0;

  initial begin
    rst = 1'b0; en = 1'b1; clr_urun = 1'b0;
    m_act = 0; m_t = 0; m_urun = 0; m_word = '0;
    upd();
    @(posedge clk); #1;

    // Reset held with data waiting: nothing pops until rst releases
    push(16'hA5C3);
    run(3);
    rd0 = n_rd_dut;
    rst = 1'b1;
    run(WP + 12);
    chk("a5c3_pops", n_rd_dut - rd0, 1);
    clr_urun = 1'b1; step(); clr_urun = 1'b0;
    run(5);

    // Three queued words stream back to back, then underrun
    rd0 = n_rd_dut;
    push(W'($urandom)); push(W'($urandom)); push(W'($urandom));
    run(3 * WP + 10);
    chk("stream3_pops", n_rd_dut - rd0, 3);
    clr_urun = 1'b1; step(); clr_urun = 1'b0;

    // en dropped during bit 5 of word 1: word completes, no further pop
    rd0 = n_rd_dut;
    push(W'($urandom)); push(W'($urandom));
    run(1 + 5 * BP + 3);
    en = 1'b0;
    run(WP);
    chk("en_drop_pops", n_rd_dut - rd0, 1);
    chk("en_drop_busy", {31'd0, busy}, 32'd0);
    en = 1'b1;
    run(WP + 10);
    clr_urun = 1'b1; step(); clr_urun = 1'b0;

    // clr_urun coincident with the underrun set, then alone
    push(W'($urandom));
    step();
    run(WP - 1);
    clr_urun = 1'b1; step();
    clr_urun = 1'b0; step();
    chk("urun_priority", {31'd0, underrun}, 32'd1);
    clr_urun = 1'b1; step();
    clr_urun = 1'b0; step();
    chk("urun_cleared", {31'd0, underrun}, 32'd0);

    // Reset during bit 7 discards the word; a fresh word then streams normally
    push(W'($urandom));
    step();
    run(7 * BP + 3);
    rst = 1'b0; step();
    rst = 1'b1; step();
    push(16'h8001);
    run(WP + 5);
    clr_urun = 1'b1; step(); clr_urun = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) push(W'($urandom));
      if ($urandom_range(0, 249) == 0) en = ~en;
      clr_urun = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 899) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
